// File: rtl/raster_edge_setup.sv
// raster_edge_setup: latches quad vertices in vblank, computes both triangles' edge values serially, steps them per line
module raster_edge_setup #(
  parameter int H_STEP_X = 640,
  parameter int MUL_W = 20
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [9:0]              x,
  input  logic [9:0]              y,
  input  logic signed [MUL_W-1:0] x_screen_v0,
  input  logic signed [MUL_W-1:0] x_screen_v1,
  input  logic signed [MUL_W-1:0] x_screen_v2,
  input  logic signed [MUL_W-1:0] x_screen_v3,
  input  logic signed [MUL_W-1:0] y_screen_v0,
  input  logic signed [MUL_W-1:0] y_screen_v1,
  input  logic signed [MUL_W-1:0] y_screen_v2,
  input  logic signed [MUL_W-1:0] y_screen_v3,
  output logic signed [MUL_W-1:0] y_screen_q_v0,
  output logic signed [MUL_W-1:0] y_screen_q_v1,
  output logic signed [MUL_W-1:0] y_screen_q_v2,
  output logic signed [MUL_W-1:0] y_screen_q_v3,
  output logic signed [MUL_W-1:0] e0_init_t1,
  output logic signed [MUL_W-1:0] e1_init_t1,
  output logic signed [MUL_W-1:0] e2_init_t1,
  output logic signed [MUL_W-1:0] e0_init_t2,
  output logic signed [MUL_W-1:0] e1_init_t2,
  output logic signed [MUL_W-1:0] e2_init_t2,
  output logic                    setup_busy,
  output logic                    setup_err
);
  typedef enum logic [1:0] {IDLE, LATCH, MUL, COMMIT} state_t;
  // Edge endpoints: t1 edges 0..2, t2 edges 3..5
  localparam logic [1:0] IA [6] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd2, 2'd3};
  localparam logic [1:0] IB [6] = '{2'd1, 2'd2, 2'd0, 2'd2, 2'd3, 2'd0};
  state_t state, nxt;
  logic signed [MUL_W-1:0] xq [4];
  logic signed [MUL_W-1:0] yq [4];
  logic signed [MUL_W-1:0] sh [6];
  logic signed [MUL_W-1:0] e [6];
  logic [3:0] k;
  logic [4:0] b;
  logic [2:0] ed;
  logic term, latch_pt, step_pt, last;
  logic signed [MUL_W-1:0] xa, xb, ya, yb, mcand, mplier, pp;
  assign latch_pt = y == 10'd480 && x == 10'd0;
  assign step_pt = state == IDLE && x == 10'(H_STEP_X) && y <= 10'd478;
  assign last = k == 4'd11 && b == 5'd19;
  assign ed = k[3:1];
  assign term = k[0];
  // Each edge is ya*(xb-xa) added, then xa*(yb-ya) subtracted, one multiplier bit per cycle
  always_comb begin
    xa = xq[IA[ed]];
    xb = xq[IB[ed]];
    ya = yq[IA[ed]];
    yb = yq[IB[ed]];
    mcand = term ? yb - ya : xb - xa;
    mplier = term ? xa : ya;
    pp = mplier[b] ? mcand << b : '0;
    nxt = latch_pt ? LATCH
        : state == LATCH ? MUL
        : state == MUL && last ? COMMIT
        : state == COMMIT ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      k <= '0;
      b <= '0;
      setup_err <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        xq[i] <= '0;
        yq[i] <= '0;
      end
      for (int i = 0; i < 6; i++) begin
        sh[i] <= '0;
        e[i] <= '0;
      end
    end else begin
      state <= nxt;
      if (x == 10'd799 && y == 10'd524 && state != IDLE) setup_err <= 1'b1;
      if (latch_pt) begin
        xq <= '{x_screen_v0, x_screen_v1, x_screen_v2, x_screen_v3};
        yq <= '{y_screen_v0, y_screen_v1, y_screen_v2, y_screen_v3};
      end
      if (state == LATCH) begin
        k <= '0;
        b <= '0;
        for (int i = 0; i < 6; i++) sh[i] <= '0;
      end
      if (state == MUL) begin
        sh[ed] <= term ? sh[ed] - pp : sh[ed] + pp;
        b <= b == 5'd19 ? 5'd0 : b + 5'd1;
        k <= b == 5'd19 ? k + 4'd1 : k;
      end
      if (state == COMMIT) e <= sh;
      if (step_pt)
        for (int i = 0; i < 6; i++) e[i] <= e[i] + xq[IA[i]] - xq[IB[i]];
    end
  end
  assign setup_busy = state != IDLE;
  assign {y_screen_q_v0, y_screen_q_v1, y_screen_q_v2, y_screen_q_v3} = {yq[0], yq[1], yq[2], yq[3]};
  assign {e0_init_t1, e1_init_t1, e2_init_t1} = {e[0], e[1], e[2]};
  assign {e0_init_t2, e1_init_t2, e2_init_t2} = {e[3], e[4], e[5]};
endmodule

// File: tb/tb_raster_edge_setup.sv
// tb_raster_edge_setup: directed checks of frame setup, line stepping, wrap, error flag and reset
module tb_raster_edge_setup;
  logic clk = 0;
  logic reset = 1;
  logic [9:0] x = 0, y = 0;
  logic signed [19:0] xs [4];
  logic signed [19:0] ys [4];
  logic signed [19:0] yq0, yq1, yq2, yq3, a1, b1, c1, a2, b2, c2;
  logic setup_busy, setup_err;
  int checks = 0, errors = 0, n;
  raster_edge_setup dut (
    .clk(clk), .reset(reset), .x(x), .y(y),
    .x_screen_v0(xs[0]), .x_screen_v1(xs[1]), .x_screen_v2(xs[2]), .x_screen_v3(xs[3]),
    .y_screen_v0(ys[0]), .y_screen_v1(ys[1]), .y_screen_v2(ys[2]), .y_screen_v3(ys[3]),
    .y_screen_q_v0(yq0), .y_screen_q_v1(yq1), .y_screen_q_v2(yq2), .y_screen_q_v3(yq3),
    .e0_init_t1(a1), .e1_init_t1(b1), .e2_init_t1(c1),
    .e0_init_t2(a2), .e1_init_t2(b2), .e2_init_t2(c2),
    .setup_busy(setup_busy), .setup_err(setup_err)
  );
  always #5 clk = ~clk;
  task automatic tick(input int yy, input int xx);
    y = 10'(yy);
    x = 10'(xx);
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic chk_all(input string tag, input int e0, input int e1, input int e2,
                         input int f0, input int f1, input int f2);
    chk({tag, " e0_t1"}, a1, e0);
    chk({tag, " e1_t1"}, b1, e1);
    chk({tag, " e2_t1"}, c1, e2);
    chk({tag, " e0_t2"}, a2, f0);
    chk({tag, " e1_t2"}, b2, f1);
    chk({tag, " e2_t2"}, c2, f2);
  endtask
  task automatic set_basic();
    xs = '{20'sd100, 20'sd300, 20'sd200, 20'sd100};
    ys = '{20'sd50, 20'sd50, 20'sd250, 20'sd250};
  endtask
  task automatic wait_setup(output int cnt);
    cnt = 0;
    while (setup_busy && cnt < 400) begin
      cnt++;
      tick(480, cnt);
    end
  endtask
  initial begin
    set_basic();
    tick(0, 0);
    tick(0, 0);
    reset = 0;
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    chk("reset busy", setup_busy, 0);
    chk("reset err", setup_err, 0);
    chk("reset yq0", yq0, 0);
    tick(479, 799);
    tick(480, 0);
    chk("yq0", yq0, 50);
    chk("yq1", yq1, 50);
    chk("yq2", yq2, 250);
    chk("yq3", yq3, 250);
    wait_setup(n);
    chk("busy cycles", n, 242);
    chk_all("setup", 10000, -65000, 15000, -15000, -25000, 20000);
    chk("err after setup", setup_err, 0);
    tick(524, 799);
    chk_all("524,799", 10000, -65000, 15000, -15000, -25000, 20000);
    chk("err 524", setup_err, 0);
    tick(0, 639);
    chk("before step e0_t1", a1, 10000);
    tick(0, 640);
    chk_all("0,640", 9800, -64900, 15100, -15100, -24900, 20000);
    for (int i = 1; i <= 478; i++) begin
      if (i == 10) begin
        tick(10, 0);
        xs = '{20'sd7, -20'sd33, 20'sd900, 20'sd5};
        ys = '{-20'sd400, 20'sd12, 20'sd77, 20'sd1000};
      end
      tick(i, 640);
    end
    tick(478, 799);
    chk_all("478,799", -85800, -17100, 62900, -62900, 22900, 20000);
    chk("isolation yq3", yq3, 250);
    tick(479, 640);
    tick(479, 799);
    chk_all("line 479", -85800, -17100, 62900, -62900, 22900, 20000);
    xs = '{20'sd1000, 20'sd1000, 20'sd0, 20'sd0};
    ys = '{20'sd0, 20'sd1000, 20'sd0, 20'sd0};
    tick(480, 0);
    wait_setup(n);
    chk("wrap busy cycles", n, 242);
    chk("wrap e0_t1", a1, 48576);
    chk("wrap e1_t1", b1, 0);
    chk("wrap yq1", yq1, 1000);
    set_basic();
    tick(480, 0);
    tick(524, 799);
    chk("err set", setup_err, 1);
    tick(480, 1);
    wait_setup(n);
    chk("err sticky", setup_err, 1);
    chk_all("after err setup", 10000, -65000, 15000, -15000, -25000, 20000);
    tick(480, 0);
    for (int i = 1; i <= 100; i++) tick(480, i);
    chk("mid-mul busy", setup_busy, 1);
    reset = 1;
    tick(480, 101);
    reset = 0;
    chk_all("mid reset", 0, 0, 0, 0, 0, 0);
    chk("mid reset busy", setup_busy, 0);
    chk("mid reset err", setup_err, 0);
    chk("mid reset yq2", yq2, 0);
    for (int i = 102; i <= 300; i++) tick(480, i);
    chk_all("no commit", 0, 0, 0, 0, 0, 0);
    tick(524, 799);
    chk_all("524 after reset", 0, 0, 0, 0, 0, 0);
    chk("err after reset", setup_err, 0);
    tick(0, 640);
    chk("step on zero", a1, 0);
    tick(480, 0);
    wait_setup(n);
    chk("resetup busy cycles", n, 242);
    chk_all("resetup", 10000, -65000, 15000, -15000, -25000, 20000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
